multicycle_control: RTL and testbench

//  Moore/Mealy FSM sequencing the shared-ALU, shared-memory multicycle MIPS-32 datapath.

---
 rtl/multicycle_control.sv | 220 ++++++++++++++++++++++
 tb/tb_multicycle_control.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
// Multicycle MIPS-32 control FSM: sequences fetch/decode/execute/memory/writeback
// over a shared ALU and memory, with a MemReady handshake and a memory-wait watchdog.
module multicycle_control #(
  parameter int MEM_TIMEOUT = 15,
  parameter int TIMEOUT_W   = 4
) (
  input  logic       Clk,
  input  logic       reset,
  input  logic [5:0] Opcode,
  input  logic [5:0] Funct,
  input  logic       Zero,
  input  logic       MemReady,
  input  logic       Halt,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       IRWrite,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       MemToReg,
  output logic       RegDst,
  output logic       RegWrite,
  output logic       JAL,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] PCSource,
  output logic       IllegalOp,
  output logic       MemFault,
  output logic [3:0] State
);

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,
    S_MEMWB  = 4'd5,
    S_MEMWR  = 4'd6,
    S_EXR    = 4'd7,
    S_RWB    = 4'd8,
    S_BEQ    = 4'd9,
    S_J      = 4'd10,
    S_JAL    = 4'd11,
    S_JR     = 4'd12,
    S_ADDIEX = 4'd13,
    S_ADDIWB = 4'd14,
    S_FAULT  = 4'd15
  } state_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_JAL  = 6'b000011;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] FN_JR   = 6'b001000;

  localparam logic [TIMEOUT_W-1:0] LIMIT =
    TIMEOUT_W'(MEM_TIMEOUT - 1);

  state_t               state;
  state_t               state_n;
  state_t               bnd;
  logic [TIMEOUT_W-1:0] cnt;
  logic                 in_wait;
  logic                 at_limit;

  // Zero is consumed by the datapath together with PCWriteCond
  logic unused_zero;
  assign unused_zero = Zero;

  assign State    = state;
  assign in_wait  = (state == S_FETCH) || (state == S_MEMRD)
                 || (state == S_MEMWR);
  assign at_limit = (cnt == LIMIT);

  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (!in_wait || MemReady || state_n != state) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  always_comb begin
    state_n     = state;
    bnd         = Halt ? S_IDLE : S_FETCH;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    IRWrite     = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    MemToReg    = 1'b0;
    RegDst      = 1'b0;
    RegWrite    = 1'b0;
    JAL         = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    ALUOp       = 2'b00;
    PCSource    = 2'b00;
    IllegalOp   = 1'b0;
    MemFault    = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (!Halt) state_n = S_FETCH;
      end
      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        if (MemReady) begin
          IRWrite = 1'b1;
          PCWrite = 1'b1;
          state_n = S_DECODE;
        end else if (at_limit) begin
          state_n = S_FAULT;
        end
      end
      S_DECODE: begin
        ALUSrcB = 2'b11;
        case (Opcode)
          OP_R:    state_n = (Funct == FN_JR) ? S_JR : S_EXR;
          OP_LW,
          OP_SW:   state_n = S_MEMADR;
          OP_BEQ:  state_n = S_BEQ;
          OP_J:    state_n = S_J;
          OP_JAL:  state_n = S_JAL;
          OP_ADDI: state_n = S_ADDIEX;
          default: begin
            IllegalOp = 1'b1;
            state_n   = bnd;
          end
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        state_n = (Opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
        if (MemReady)      state_n = S_MEMWB;
        else if (at_limit) state_n = S_FAULT;
      end
      S_MEMWB: begin
        MemToReg = 1'b1;
        RegWrite = 1'b1;
        state_n  = bnd;
      end
      S_MEMWR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
        if (MemReady)      state_n = bnd;
        else if (at_limit) state_n = S_FAULT;
      end
      S_EXR: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'b10;
        state_n = S_RWB;
      end
      S_RWB: begin
        RegDst   = 1'b1;
        RegWrite = 1'b1;
        state_n  = bnd;
      end
      S_BEQ: begin
        ALUSrcA     = 1'b1;
        ALUOp       = 2'b01;
        PCWriteCond = 1'b1;
        PCSource    = 2'b01;
        state_n     = bnd;
      end
      S_J: begin
        PCWrite  = 1'b1;
        PCSource = 2'b10;
        state_n  = bnd;
      end
      S_JAL: begin
        PCWrite  = 1'b1;
        PCSource = 2'b10;
        JAL      = 1'b1;
        RegWrite = 1'b1;
        state_n  = bnd;
      end
      S_JR: begin
        PCWrite  = 1'b1;
        PCSource = 2'b11;
        state_n  = bnd;
      end
      S_ADDIEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        state_n = S_ADDIWB;
      end
      S_ADDIWB: begin
        RegWrite = 1'b1;
        state_n  = bnd;
      end
      S_FAULT: begin
        MemFault = 1'b1;
      end
      default: state_n = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: walks each instruction class
// through its state sequence and checks every control output per cycle.
module tb_multicycle_control;

  logic       Clk = 1'b0;
  logic       reset;
  logic [5:0] Opcode;
  logic [5:0] Funct;
  logic       Zero;
  logic       MemReady;
  logic       Halt;
  logic       PCWrite, PCWriteCond, IorD, IRWrite, MemRead, MemWrite;
  logic       MemToReg, RegDst, RegWrite, JAL, ALUSrcA;
  logic [1:0] ALUSrcB, ALUOp, PCSource;
  logic       IllegalOp, MemFault;
  logic [3:0] State;

  int n_cmp = 0;
  int n_bad = 0;

  localparam logic [18:0] PCW  = 19'h40000;
  localparam logic [18:0] PWC  = 19'h20000;
  localparam logic [18:0] IORD = 19'h10000;
  localparam logic [18:0] IRW  = 19'h08000;
  localparam logic [18:0] MRD  = 19'h04000;
  localparam logic [18:0] MWR  = 19'h02000;
  localparam logic [18:0] M2R  = 19'h01000;
  localparam logic [18:0] RDST = 19'h00800;
  localparam logic [18:0] RW   = 19'h00400;
  localparam logic [18:0] CJAL = 19'h00200;
  localparam logic [18:0] SRCA = 19'h00100;
  localparam logic [18:0] B01  = 19'h00040;
  localparam logic [18:0] B10  = 19'h00080;
  localparam logic [18:0] B11  = 19'h000C0;
  localparam logic [18:0] OP01 = 19'h00010;
  localparam logic [18:0] OP10 = 19'h00020;
  localparam logic [18:0] PS01 = 19'h00004;
  localparam logic [18:0] PS10 = 19'h00008;
  localparam logic [18:0] PS11 = 19'h0000C;
  localparam logic [18:0] ILL  = 19'h00002;
  localparam logic [18:0] FLT  = 19'h00001;

  localparam logic [18:0] FETCH_OK = PCW | IRW | MRD | B01;

  logic [18:0] ctl;
  assign ctl = {PCWrite, PCWriteCond, IorD, IRWrite, MemRead, MemWrite,
                MemToReg, RegDst, RegWrite, JAL, ALUSrcA, ALUSrcB,
                ALUOp, PCSource, IllegalOp, MemFault};

  multicycle_control #(.MEM_TIMEOUT(15), .TIMEOUT_W(4)) dut (
    .Clk(Clk), .reset(reset), .Opcode(Opcode), .Funct(Funct),
    .Zero(Zero), .MemReady(MemReady), .Halt(Halt),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
    .IRWrite(IRWrite), .MemRead(MemRead), .MemWrite(MemWrite),
    .MemToReg(MemToReg), .RegDst(RegDst), .RegWrite(RegWrite),
    .JAL(JAL), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
    .PCSource(PCSource), .IllegalOp(IllegalOp), .MemFault(MemFault),
    .State(State)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // check state and controls for this cycle, then advance one clock
  task automatic step(input string tag, input logic [3:0] es,
                      input logic [18:0] ec);
    #1;
    chk({tag, ".state"}, 32'(State), 32'(es));
    chk({tag, ".ctl"}, 32'(ctl), 32'(ec));
    @(posedge Clk);
    #1;
  endtask

  initial begin
    reset = 1'b0; Halt = 1'b1; MemReady = 1'b1;
    Opcode = 6'd0; Funct = 6'h20; Zero = 1'b0;
    #2;
    chk("reset.state", 32'(State), 32'd0);
    chk("reset.ctl", 32'(ctl), 32'd0);
    repeat (2) @(posedge Clk);
    #1;
    reset = 1'b1;
    step("idle_halt", 4'd0, 19'd0);
    step("idle_halt2", 4'd0, 19'd0);
    Halt = 1'b0;
    // add $3,$1,$2
    step("add.idle", 4'd0, 19'd0);
    step("add.fetch", 4'd1, FETCH_OK);
    step("add.decode", 4'd2, B11);
    step("add.exr", 4'd7, SRCA | OP10);
    step("add.rwb", 4'd8, RDST | RW);
    // lw with 3 wait cycles in MEMRD
    Opcode = 6'b100011;
    step("lw.fetch", 4'd1, FETCH_OK);
    step("lw.decode", 4'd2, B11);
    step("lw.memadr", 4'd3, SRCA | B10);
    MemReady = 1'b0;
    step("lw.memrd0", 4'd4, MRD | IORD);
    step("lw.memrd1", 4'd4, MRD | IORD);
    step("lw.memrd2", 4'd4, MRD | IORD);
    MemReady = 1'b1;
    step("lw.memrd3", 4'd4, MRD | IORD);
    step("lw.memwb", 4'd5, M2R | RW);
    // beq taken
    Opcode = 6'b000100; Zero = 1'b1;
    step("beq.fetch", 4'd1, FETCH_OK);
    step("beq.decode", 4'd2, B11);
    step("beq.exec", 4'd9, SRCA | OP01 | PWC | PS01);
    // jal, Halt raised mid-instruction is ignored
    Opcode = 6'b000011; Zero = 1'b0;
    step("jal.fetch", 4'd1, FETCH_OK);
    Halt = 1'b1;
    step("jal.decode", 4'd2, B11);
    Halt = 1'b0;
    step("jal.exec", 4'd11, PCW | PS10 | CJAL | RW);
    // jr $31
    Opcode = 6'b000000; Funct = 6'b001000;
    step("jr.fetch", 4'd1, FETCH_OK);
    step("jr.decode", 4'd2, B11);
    step("jr.exec", 4'd12, PCW | PS11);
    // j
    Opcode = 6'b000010;
    step("j.fetch", 4'd1, FETCH_OK);
    step("j.decode", 4'd2, B11);
    step("j.exec", 4'd10, PCW | PS10);
    // addi
    Opcode = 6'b001000;
    step("addi.fetch", 4'd1, FETCH_OK);
    step("addi.decode", 4'd2, B11);
    step("addi.ex", 4'd13, SRCA | B10);
    step("addi.wb", 4'd14, RW);
    // illegal opcode
    Opcode = 6'b111111;
    step("ill.fetch", 4'd1, FETCH_OK);
    step("ill.decode", 4'd2, B11 | ILL);
    // fetch wait with Halt does not stall into IDLE
    MemReady = 1'b0; Halt = 1'b1;
    Opcode = 6'b101011;
    step("sw.fetchwait", 4'd1, MRD | B01);
    MemReady = 1'b1; Halt = 1'b0;
    step("sw.fetch", 4'd1, FETCH_OK);
    step("sw.decode", 4'd2, B11);
    step("sw.memadr", 4'd3, SRCA | B10);
    // ready on the limit cycle completes normally, Halt parks in IDLE
    MemReady = 1'b0;
    for (int i = 0; i < 14; i++) step("sw.wait", 4'd6, MWR | IORD);
    MemReady = 1'b1; Halt = 1'b1;
    step("sw.limitready", 4'd6, MWR | IORD);
    step("sw.halted", 4'd0, 19'd0);
    Halt = 1'b0;
    step("sw2.idle", 4'd0, 19'd0);
    step("sw2.fetch", 4'd1, FETCH_OK);
    step("sw2.decode", 4'd2, B11);
    step("sw2.memadr", 4'd3, SRCA | B10);
    // MemReady stuck low: 15 cycles then FAULT
    MemReady = 1'b0;
    for (int i = 0; i < 15; i++) step("sw2.stuck", 4'd6, MWR | IORD);
    step("sw2.fault", 4'd15, FLT);
    MemReady = 1'b1;
    step("fault.hold", 4'd15, FLT);
    step("fault.hold2", 4'd15, FLT);
    // asynchronous reset leaves FAULT without a clock edge
    @(negedge Clk);
    reset = 1'b0;
    #1;
    chk("async_reset.state", 32'(State), 32'd0);
    chk("async_reset.ctl", 32'(ctl), 32'd0);
    @(posedge Clk);
    #1;
    reset = 1'b1;
    Opcode = 6'b000000; Funct = 6'h20;
    step("post.idle", 4'd0, 19'd0);
    step("post.fetch", 4'd1, FETCH_OK);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
